// File: rtl/alarm_zone_controller.sv
// Multi-zone intrusion supervisor: exit delay, entry countdown, passcode attempt limit, sticky trip record.
// All outputs registered, one cycle after the causing input; no backpressure, every input is acted on the cycle it arrives.
module alarm_zone_controller #(
    parameter int CLK_HZ        = 50000000,
    parameter int NUM_ZONES     = 4,
    parameter int ARM_DELAY_S   = 10,
    parameter int ENTRY_DELAY_S = 20,
    parameter int MAX_ATTEMPTS  = 3,
    parameter int TIMER_W       = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  arm_req,
    input  logic [NUM_ZONES-1:0]                  zone_tripped,
    input  logic [NUM_ZONES-1:0]                  zone_enable,
    input  logic                                  code_strobe,
    input  logic                                  code_ok,
    output logic [2:0]                            state,
    output logic [TIMER_W-1:0]                    seconds_left,
    output logic [NUM_ZONES-1:0]                  tripped_zones,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts,
    output logic                                  alarm_out,
    output logic                                  arm_fault
);

    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMING = 3'd1,
        S_ARMED  = 3'd2,
        S_ENTRY  = 3'd3,
        S_ALERT  = 3'd4
    } state_t;

    state_t             st;
    logic [PRE_W-1:0]   presc;
    logic               tick;
    logic [NUM_ZONES-1:0] hits;
    logic               trip_hit;
    logic               code_good;
    logic               code_bad;
    logic [ATT_W-1:0]   att_inc;
    logic               timer_dec;
    logic               timer_exp;
    logic               to_idle;

    assign tick      = (presc == PRE_W'(CLK_HZ - 1));
    assign hits      = zone_tripped & zone_enable;
    assign trip_hit  = |hits;
    assign code_good = code_strobe & code_ok;
    assign code_bad  = code_strobe & ~code_ok;
    assign att_inc   = attempts + ATT_W'(1);
    assign timer_dec = tick && (seconds_left != '0);
    assign timer_exp = tick && (seconds_left == TIMER_W'(1));
    // A correct code outranks everything outside IDLE; illegal encodings also recover here.
    assign to_idle   = ((st != S_IDLE) && code_good) || (st > S_ALERT);
    assign state     = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st            <= S_IDLE;
            presc         <= '0;
            seconds_left  <= '0;
            tripped_zones <= '0;
            attempts      <= '0;
            alarm_out     <= 1'b0;
            arm_fault     <= 1'b0;
        end else begin
            arm_fault <= 1'b0;
            presc     <= tick ? '0 : presc + PRE_W'(1);
            if (to_idle) begin
                st            <= S_IDLE;
                presc         <= '0;
                seconds_left  <= '0;
                tripped_zones <= '0;
                attempts      <= '0;
                alarm_out     <= 1'b0;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (arm_req) begin
                            if (!trip_hit) begin
                                st           <= S_ARMING;
                                presc        <= '0;
                                seconds_left <= TIMER_W'(ARM_DELAY_S);
                            end else begin
                                arm_fault <= 1'b1;
                            end
                        end
                    end
                    S_ARMING: begin
                        if (timer_dec) begin
                            seconds_left <= seconds_left - TIMER_W'(1);
                            if (timer_exp) begin
                                st    <= S_ARMED;
                                presc <= '0;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (trip_hit) begin
                            st            <= S_ENTRY;
                            presc         <= '0;
                            tripped_zones <= hits;
                            seconds_left  <= TIMER_W'(ENTRY_DELAY_S);
                            attempts      <= '0;
                        end
                    end
                    S_ENTRY: begin
                        tripped_zones <= tripped_zones | hits;
                        if (code_bad) begin
                            attempts <= att_inc;
                        end
                        // Attempt limit and countdown expiry both land in ALERT; the count is kept either way.
                        if ((code_bad && (att_inc == ATT_W'(MAX_ATTEMPTS))) || timer_exp) begin
                            st           <= S_ALERT;
                            presc        <= '0;
                            seconds_left <= '0;
                            alarm_out    <= 1'b1;
                        end else if (timer_dec) begin
                            seconds_left <= seconds_left - TIMER_W'(1);
                        end
                    end
                    S_ALERT: begin
                        tripped_zones <= tripped_zones | hits;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
